// File: rtl/gb2_sc_pkg.sv
// Shared types and constants for the stochastic-computing kernel sequencer.
package gb2_sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Default pixel precision, also the data-LFSR width.
  localparam int W_DEF = 8;

  // Number of data inputs on the kernel core; fixed by the core itself.
  localparam int N_PIX = 14;

  // Select LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] SEL_SEED_DEF = 16'hACE1;
  localparam logic [15:0] SEL_TAPS     = 16'hB400;

  // Maximal-length Fibonacci tap mask for a shift-left register of width w.
  // Bit i set means stage i+1 feeds the XOR that enters bit 0.
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] t;
    t = '0;
    case (w)
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR with synchronous load and step enable.
module sc_lfsr #(
  parameter int               WIDTH   = 8,
  parameter int               OUT_W   = WIDTH,
  parameter logic [WIDTH-1:0] TAPS    = '0,
  parameter logic [WIDTH-1:0] RST_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  output logic [OUT_W-1:0] state_o
);

  logic [WIDTH-1:0] state_q, state_d;

  // Next state: load has priority over step; otherwise hold.
  always_comb begin
    // NOTE: assigning the default first makes every path drive state_d, so no latch is inferred.
    state_d = state_q;
    if (load_i) begin
      state_d = load_val_i;
    end else if (step_i) begin
      state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= RST_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/gb2_sc_sequencer.sv
// Drives a 2-output stochastic-computing kernel core through one bitstream
// evaluation and returns the ones counts of both outputs via valid/ready.
module gb2_sc_sequencer
  import gb2_sc_pkg::*;
#(
  parameter int          W        = W_DEF,
  parameter logic [15:0] SEL_SEED = SEL_SEED_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [W:0]           len_i,
  input  logic [W-1:0]         seed_i,
  input  logic [N_PIX*W-1:0]   pix_i,
  output logic                 busy_o,
  output logic [N_PIX+3:0]     core_x_o,
  output logic                 core_xv_o,
  input  logic [1:0]           core_z_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [W:0]           res1_o,
  output logic [W:0]           res0_o
);

  localparam logic [W-1:0] D_TAPS  = W'(lfsr_taps(W));
  localparam logic [W:0]   CNT_ONE = {{W{1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [N_PIX*W-1:0]   pix_q, pix_d;
  logic [W:0]           len_q, len_d;
  logic [W:0]           gen_cnt_q, gen_cnt_d;
  logic [W:0]           acc1_q, acc1_d;
  logic [W:0]           acc0_q, acc0_d;
  logic                 lfsr_load, lfsr_step;
  logic [W-1:0]         seed_fix;
  logic [W-1:0]         data_lfsr;
  logic [3:0]           sel_lfsr;

  // A zero seed would lock the data LFSR, so it is replaced by 1.
  assign seed_fix = (seed_i == '0) ? {{(W-1){1'b0}}, 1'b1} : seed_i;

  sc_lfsr #(
    .WIDTH   (W),
    .OUT_W   (W),
    .TAPS    (D_TAPS),
    .RST_VAL ({{(W-1){1'b0}}, 1'b1})
  ) u_data_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lfsr_load),
    .load_val_i (seed_fix),
    .step_i     (lfsr_step),
    .state_o    (data_lfsr)
  );

  sc_lfsr #(
    .WIDTH   (16),
    .OUT_W   (4),
    .TAPS    (SEL_TAPS),
    .RST_VAL (SEL_SEED)
  ) u_sel_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lfsr_load),
    .load_val_i (SEL_SEED),
    .step_i     (lfsr_step),
    .state_o    (sel_lfsr)
  );

  // FSM next state, job capture in IDLE and accumulation in RUN.
  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    len_d     = len_q;
    gen_cnt_d = gen_cnt_q;
    acc1_d    = acc1_q;
    acc0_d    = acc0_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pix_d     = pix_i;
          len_d     = len_i;
          gen_cnt_d = '0;
          acc1_d    = '0;
          acc0_d    = '0;
          lfsr_load = 1'b1;
          state_d   = (len_i != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        acc1_d    = acc1_q + {{W{1'b0}}, core_z_i[1]};
        acc0_d    = acc0_q + {{W{1'b0}}, core_z_i[0]};
        gen_cnt_d = gen_cnt_q + CNT_ONE;
        lfsr_step = 1'b1;
        if (gen_cnt_q == len_q - CNT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      // NOTE: the wide pixel register is reset too, so nothing downstream ever sees X after reset.
      pix_q     <= '0;
      len_q     <= '0;
      gen_cnt_q <= '0;
      acc1_q    <= '0;
      acc0_q    <= '0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      len_q     <= len_d;
      gen_cnt_q <= gen_cnt_d;
      acc1_q    <= acc1_d;
      acc0_q    <= acc0_d;
    end
  end

  // Bitstream generation: every pixel compares against the same data LFSR value.
  always_comb begin
    core_x_o = '0;
    if (state_q == ST_RUN) begin
      core_x_o[3:0] = sel_lfsr;
      for (int k = 0; k < N_PIX; k++) begin
        core_x_o[4+k] = (pix_q[k*W +: W] >= data_lfsr);
      end
    end
  end

  assign core_xv_o   = (state_q == ST_RUN);
  assign busy_o      = (state_q != ST_IDLE);
  assign res_valid_o = (state_q == ST_DONE);
  assign res1_o      = res_valid_o ? acc1_q : '0;
  assign res0_o      = res_valid_o ? acc0_q : '0;

endmodule

// File: tb/tb_gb2_sc_sequencer.sv
// Scoreboard bench for gb2_sc_sequencer with a behavioural mux-structured kernel core.
module tb_gb2_sc_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [8:0]   len = '0;
  logic [7:0]   seed = '0;
  logic [111:0] pix = '0;
  logic         res_ready = 1'b1;
  logic         busy, core_xv, res_valid;
  logic [17:0]  core_x;
  logic [1:0]   core_z;
  logic [8:0]   res1, res0;

  int n_vec = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  // Kernel core: z1 picks one of pixels 0..7, z0 one of pixels 8..13, steered by the select bits.
  function automatic logic [1:0] core_fn(input logic [17:0] x);
    logic [1:0] z;
    z[1] = x[4 + int'(x[2:0])];
    z[0] = x[3] ? x[12 + int'(x[1:0])] : (x[0] ? x[17] : x[16]);
    return z;
  endfunction

  assign core_z = core_fn(core_x);

  gb2_sc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .len_i       (len),
    .seed_i      (seed),
    .pix_i       (pix),
    .busy_o      (busy),
    .core_x_o    (core_x),
    .core_xv_o   (core_xv),
    .core_z_i    (core_z),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res1_o      (res1),
    .res0_o      (res0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference evaluation: {res1, res0} for one job.
  function automatic logic [17:0] model(input logic [111:0] p, input logic [8:0] l, input logic [7:0] s);
    logic [7:0]  d;
    logic [15:0] sl;
    logic [8:0]  a1, a0;
    logic [17:0] x;
    logic [1:0]  z;
    d  = (s == 8'd0) ? 8'd1 : s;
    sl = 16'hACE1;
    a1 = '0;
    a0 = '0;
    for (int i = 0; i < int'(l); i++) begin
      x[3:0] = sl[3:0];
      for (int k = 0; k < 14; k++) x[4+k] = (p[k*8 +: 8] >= d);
      z  = core_fn(x);
      a1 = a1 + {8'd0, z[1]};
      a0 = a0 + {8'd0, z[0]};
      d  = {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
      sl = {sl[14:0], sl[15] ^ sl[13] ^ sl[12] ^ sl[10]};
    end
    return {a1, a0};
  endfunction

  // Monitor: compares every presented result against the scoreboard head; pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", exp_q.size(), 1);
        end else begin
          check("res1", res1, exp_q[0][17:9]);
          check("res0", res0, exp_q[0][8:0]);
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_job(input logic [111:0] p, input logic [8:0] l, input logic [7:0] s,
                         input logic [17:0] expv, input bit hold);
    int lat;
    int xv;
    @(posedge clk); #1;
    pix = p; len = l; seed = s; start = 1'b1; res_ready = !hold;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    start = 1'b0;
    pix = ~p; len = 9'd3; seed = ~s;
    lat = 1;
    xv  = 0;
    while (!res_valid && lat < 1000) begin
      if (core_xv) xv++;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 32'(l) + 1);
    check("xv_cycles", xv, 32'(l));
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        start = i[0];
        @(posedge clk); #1;
        check("hold_busy", busy, 1);
        check("hold_valid", res_valid, 1);
      end
      start = 1'b0;
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("valid_drop", res_valid, 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    logic [111:0] rp, rp2;
    for (int k = 0; k < 14; k++) begin
      rp[k*8 +: 8]  = 8'($urandom);
      rp2[k*8 +: 8] = 8'($urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_core_x", core_x, 0);
    check("rst_xv", core_xv, 0);
    check("rst_res1", res1, 0);
    check("rst_res0", res0, 0);
    rst_n = 1'b1;

    run_job({14{8'd0}},   9'd255, 8'd1,   {9'd0,   9'd0},   1'b0);
    run_job({14{8'd255}}, 9'd255, 8'h33,  {9'd255, 9'd255}, 1'b0);
    run_job({14{8'd128}}, 9'd255, 8'hC7,  {9'd128, 9'd128}, 1'b0);
    run_job(rp,           9'd0,   8'h11,  {9'd0,   9'd0},   1'b1);
    run_job(rp,           9'd255, 8'h5A,  model(rp, 9'd255, 8'h5A), 1'b0);
    run_job(rp2,          9'd256, 8'h03,  model(rp2, 9'd256, 8'h03), 1'b0);

    // Abort a job with reset partway through RUN.
    @(posedge clk); #1;
    pix = rp; len = 9'd255; seed = 8'h5A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    check("midrun_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_xv", core_xv, 0);
    check("abort_core_x", core_x, 0);
    check("abort_valid", res_valid, 0);
    rst_n = 1'b1;

    run_job(rp2, 9'd100, 8'h00, model(rp2, 9'd100, 8'h00), 1'b0);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
